// File: rtl/decimal_to_binary_entry_if.sv
// Keypad-side bus for decimal_to_binary_entry: key handshake in, fixed-point result and status out.
// master drives keys (keypad/testbench); slave is the converter.
interface decimal_to_binary_entry_if #(
   parameter int unsigned OUT_W = 16
) ();
   logic             key_valid;
   logic [3:0]       key_code;
   logic             key_ready;
   logic             busy;
   logic [OUT_W-1:0] binary_out;
   logic             out_valid;
   logic             err;

   modport master (
      output key_valid, key_code,
      input  key_ready, busy, binary_out, out_valid, err
   );

   modport slave (
      input  key_valid, key_code,
      output key_ready, busy, binary_out, out_valid, err
   );
endinterface

// File: rtl/decimal_to_binary_entry.sv
// Keypad decimal entry (+-NN.NN) converted to two's complement Q(OUT_W-FRAC_W).FRAC_W.
// Define DEC2BIN_ROUND_EN to round the fraction to nearest LSB instead of truncating.
module decimal_to_binary_entry #(
   parameter int unsigned FRAC_W = 6,
   parameter int unsigned OUT_W  = 16
) (
   input logic                      clk,
   input logic                      rst,
   decimal_to_binary_entry_if.slave dec_if
);

   // Holds 99 * 2^FRAC_W + 50 for every supported FRAC_W.
   localparam int unsigned RW = FRAC_W + 7;
`ifdef DEC2BIN_ROUND_EN
   localparam int unsigned Bias = 50;
`else
   localparam int unsigned Bias = 0;
`endif

   typedef enum logic [1:0] {StEntry, StLoad, StDiv, StDone} state_e;

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [3:0]        tens_q, tens_d, units_q, units_d;
   logic [3:0]        tenths_q, tenths_d, hund_q, hund_d;
   logic [1:0]        int_cnt_q, int_cnt_d, frac_cnt_q, frac_cnt_d;
   logic              point_q, point_d;
   logic              err_q, err_d;
   logic              new_entry_q, new_entry_d;
   logic [RW-1:0]     rem_q, rem_d, dsr_q, dsr_d;
   logic [FRAC_W-1:0] quo_q, quo_d;
   logic [3:0]        step_q, step_d;
   logic [OUT_W-1:0]  bin_q, bin_d;

   logic              accept;
   logic              is_digit;
   logic              rem_ge;
   logic [6:0]        int_val, frac_val;
   logic [OUT_W-1:0]  mag;

   assign accept   = (state_q == StEntry) && dec_if.key_valid;
   assign is_digit = dec_if.key_code <= 4'd9;
   assign int_val  = 7'(tens_q) * 7'd10 + 7'(units_q);
   assign frac_val = 7'(tenths_q) * 7'd10 + 7'(hund_q);
   assign rem_ge   = rem_q >= dsr_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StEntry;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StEntry: if (accept && dec_if.key_code == 4'hC) state_d = StLoad;
         StLoad:  state_d = StDiv;
         StDiv:   if (step_q == '0) state_d = StDone;
         StDone:  state_d = StEntry;
         default: state_d = StEntry;
      endcase
   end

   // Output logic
   always_comb begin
      dec_if.key_ready  = (state_q == StEntry);
      dec_if.busy       = (state_q == StLoad) || (state_q == StDiv);
      dec_if.out_valid  = (state_q == StDone);
      dec_if.binary_out = bin_q;
      dec_if.err        = err_q;
   end

   always_comb begin
      sign_d      = sign_q;
      tens_d      = tens_q;
      units_d     = units_q;
      tenths_d    = tenths_q;
      hund_d      = hund_q;
      int_cnt_d   = int_cnt_q;
      frac_cnt_d  = frac_cnt_q;
      point_d     = point_q;
      err_d       = err_q;
      new_entry_d = new_entry_q;
      rem_d       = rem_q;
      dsr_d       = dsr_q;
      quo_d       = quo_q;
      step_d      = step_q;
      bin_d       = bin_q;
      mag         = '0;
      case (state_q)
         StEntry: begin
            if (accept && is_digit) begin
               // First digit after a result starts a fresh entry, so stale err goes away.
               new_entry_d = 1'b0;
               if (new_entry_q) err_d = 1'b0;
               if (!point_q) begin
                  if (int_cnt_q == 2'd2) begin
                     err_d = 1'b1;
                  end else begin
                     tens_d    = units_q;
                     units_d   = dec_if.key_code;
                     int_cnt_d = int_cnt_q + 2'd1;
                  end
               end else if (frac_cnt_q == 2'd2) begin
                  err_d = 1'b1;
               end else begin
                  if (frac_cnt_q == 2'd0) tenths_d = dec_if.key_code;
                  else                    hund_d   = dec_if.key_code;
                  frac_cnt_d = frac_cnt_q + 2'd1;
               end
            end else if (accept) begin
               case (dec_if.key_code)
                  4'hA: point_d = 1'b1;
                  4'hB: sign_d  = ~sign_q;
                  4'hD: begin
                     sign_d      = 1'b0;
                     tens_d      = '0;
                     units_d     = '0;
                     tenths_d    = '0;
                     hund_d      = '0;
                     int_cnt_d   = '0;
                     frac_cnt_d  = '0;
                     point_d     = 1'b0;
                     err_d       = 1'b0;
                     new_entry_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         StLoad: begin
            rem_d  = (RW'(frac_val) << FRAC_W) + RW'(Bias);
            dsr_d  = RW'(100) << FRAC_W;
            quo_d  = '0;
            step_d = 4'(FRAC_W);
         end
         StDiv: begin
            // Divisor is pre-shifted; the first (MSB) quotient bit is always 0 and falls off.
            if (rem_ge) rem_d = rem_q - dsr_q;
            quo_d  = {quo_q[FRAC_W-2:0], rem_ge};
            dsr_d  = dsr_q >> 1;
            step_d = step_q - 4'd1;
            if (step_q == '0) begin
               mag   = (OUT_W'(int_val) << FRAC_W) | OUT_W'(quo_d);
               bin_d = sign_q ? -mag : mag;
            end
         end
         StDone: begin
            sign_d      = 1'b0;
            tens_d      = '0;
            units_d     = '0;
            tenths_d    = '0;
            hund_d      = '0;
            int_cnt_d   = '0;
            frac_cnt_d  = '0;
            point_d     = 1'b0;
            new_entry_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q      <= 1'b0;
         tens_q      <= '0;
         units_q     <= '0;
         tenths_q    <= '0;
         hund_q      <= '0;
         int_cnt_q   <= '0;
         frac_cnt_q  <= '0;
         point_q     <= 1'b0;
         err_q       <= 1'b0;
         new_entry_q <= 1'b0;
         rem_q       <= '0;
         dsr_q       <= '0;
         quo_q       <= '0;
         step_q      <= '0;
         bin_q       <= '0;
      end else begin
         sign_q      <= sign_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         tenths_q    <= tenths_d;
         hund_q      <= hund_d;
         int_cnt_q   <= int_cnt_d;
         frac_cnt_q  <= frac_cnt_d;
         point_q     <= point_d;
         err_q       <= err_d;
         new_entry_q <= new_entry_d;
         rem_q       <= rem_d;
         dsr_q       <= dsr_d;
         quo_q       <= quo_d;
         step_q      <= step_d;
         bin_q       <= bin_d;
      end
   end

endmodule

// File: tb/tb_decimal_to_binary_entry.sv
// Directed and random key sequences for decimal_to_binary_entry, checked against a decimal
// arithmetic reference model. Honours DEC2BIN_ROUND_EN like the design.
module tb_decimal_to_binary_entry;

   localparam int unsigned FRAC_W = 6;
   localparam int unsigned OUT_W  = 16;
`ifdef DEC2BIN_ROUND_EN
   localparam int Bias = 50;
`else
   localparam int Bias = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   decimal_to_binary_entry_if #(.OUT_W(OUT_W)) dif ();

   decimal_to_binary_entry #(.FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .dec_if (dif)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   // Reference model: the entered number as plain decimal quantities.
   int m_int, m_icnt, m_tenths, m_hund, m_fcnt;
   bit m_point, m_neg, m_err, m_new;

   function automatic void m_clear_entry();
      m_int = 0; m_icnt = 0; m_tenths = 0; m_hund = 0; m_fcnt = 0;
      m_point = 0; m_neg = 0;
   endfunction

   function automatic void model_key(input int code);
      if (code <= 9) begin
         if (m_new) begin m_err = 0; m_new = 0; end
         if (!m_point) begin
            if (m_icnt == 2) m_err = 1;
            else begin m_int = m_int * 10 + code; m_icnt++; end
         end else begin
            if (m_fcnt == 0) m_tenths = code;
            else if (m_fcnt == 1) m_hund = code;
            else m_err = 1;
            if (m_fcnt < 2) m_fcnt++;
         end
      end else if (code == 10) m_point = 1;
      else if (code == 11) m_neg = !m_neg;
      else if (code == 13) begin m_clear_entry(); m_err = 0; m_new = 0; end
   endfunction

   function automatic logic [OUT_W-1:0] model_value();
      int f, q, m;
      f = 10 * m_tenths + m_hund;
      q = (f * (1 << FRAC_W) + Bias) / 100;
      m = m_int * (1 << FRAC_W) + q;
      if (m_neg) m = -m;
      return OUT_W'(m);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] code);
      bit acc;
      dif.key_valid = 1'b1;
      dif.key_code  = code;
      acc = dif.key_ready;
      tick();
      dif.key_valid = 1'b0;
      if (acc && code != 4'hC) model_key(int'(code));
   endtask

   // Press enter and follow the conversion; optionally poke a digit at cycle `inject`.
   task automatic do_enter(input string tag, input int inject);
      int n, nbusy, nbad;
      logic [OUT_W-1:0] exp_v;
      logic exp_e;
      press(4'hC);
      exp_v = model_value();
      exp_e = m_err;
      m_clear_entry();
      m_new = 1;
      n = 1; nbusy = 0; nbad = 0;
      while (!dif.out_valid && n < 20) begin
         if (dif.busy) nbusy++;
         if (dif.busy && dif.key_ready) nbad++;
         if (n == inject) begin dif.key_valid = 1'b1; dif.key_code = 4'd9; end
         tick();
         dif.key_valid = 1'b0;
         n++;
      end
      chk({tag, " latency"}, n, FRAC_W + 3);
      chk({tag, " busy cycles"}, nbusy, FRAC_W + 2);
      chk({tag, " key_ready while busy"}, nbad, 0);
      chk({tag, " value"}, dif.binary_out, exp_v);
      chk({tag, " err"}, dif.err, exp_e);
      tick();
      chk({tag, " pulse width"}, dif.out_valid, 0);
      chk({tag, " hold"}, dif.binary_out, exp_v);
   endtask

   initial begin
      int pulses, len, r;
      dif.key_valid = 1'b0;
      dif.key_code  = 4'h0;
      m_clear_entry(); m_err = 0; m_new = 0;
      tick(); tick();
      rst = 1'b0;
      chk("reset binary_out", dif.binary_out, 0);
      chk("reset out_valid", dif.out_valid, 0);
      chk("reset busy", dif.busy, 0);
      chk("reset err", dif.err, 0);
      chk("reset key_ready", dif.key_ready, 1);

      // 87.12
      press(4'd8); press(4'd7); press(4'hA); press(4'd1); press(4'd2);
      do_enter("87.12", -1);
      // -87.5
      press(4'hB); press(4'd8); press(4'd7); press(4'hA); press(4'd5);
      do_enter("-87.5", -1);
      // integer overflow, err sticky through DONE, cleared by clear
      press(4'd1); press(4'd2); press(4'd3);
      do_enter("123", -1);
      chk("err after done", dif.err, 1);
      press(4'hD);
      chk("err after clear", dif.err, 0);
      chk("clear keeps binary_out", dif.binary_out, 16'h0300);
      // err cleared by first digit of the next entry
      press(4'd1); press(4'd2); press(4'd3);
      do_enter("123 again", -1);
      press(4'd5);
      chk("err after new digit", dif.err, 0);
      do_enter("5", -1);
      // .01 and third fraction digit
      press(4'hA); press(4'd0); press(4'd1);
      do_enter(".01", -1);
      press(4'hA); press(4'd9); press(4'd9); press(4'd7); press(4'hA);
      do_enter(".997", -1);
      // empty entry and minus zero
      do_enter("empty", -1);
      press(4'hB);
      do_enter("minus zero", -1);
      // digit during DIV is dropped, next entry clean
      press(4'd4);
      do_enter("4 with poke", 3);
      press(4'd5);
      do_enter("5 after poke", -1);

      // reset 4 cycles after enter aborts the conversion
      press(4'd3);
      press(4'hC);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_clear_entry(); m_err = 0; m_new = 0;
      chk("abort key_ready", dif.key_ready, 1);
      chk("abort binary_out", dif.binary_out, 0);
      chk("abort busy", dif.busy, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (dif.out_valid) pulses++;
         tick();
      end
      chk("abort no out_valid", pulses, 0);

      // reset wins over a key in the same cycle
      press(4'd7);
      rst = 1'b1; dif.key_valid = 1'b1; dif.key_code = 4'd5;
      tick();
      rst = 1'b0; dif.key_valid = 1'b0;
      m_clear_entry(); m_err = 0; m_new = 0;
      do_enter("rst priority", -1);

      // random entries
      for (int e = 0; e < 24; e++) begin
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 19);
            if (r <= 9) press(4'(r));
            else if (r <= 11) press(4'hA);
            else if (r == 12) press(4'hB);
            else if (r == 13) press(4'hD);
            else if (r == 14) press(4'hE);
            else if (r == 15) press(4'hF);
            else press(4'(r - 10));
         end
         do_enter("random", -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
